// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: valid/ready character handshake between the TX controller and
// the uart_tx serializer.
//   tx_valid : a character is available at tx_data
//   tx_ready : serializer idle; a character is taken in any cycle with both high
//   tx_data  : character offered to the serializer
// Modports: master = controller side, slave = serializer side.
interface uart_tx_ctrl_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side controller between the THR write path and uart_tx.
// Buffers written characters in a circular FIFO (capacity DEPTH in FIFO mode, 1 in
// 16450 mode), hands them to the serializer over a valid/ready handshake and
// produces the LSR THRE/TEMT bits and the THR-empty interrupt request.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_en/wr_data : THR write strobe and character
//   wr_drop       : registered pulse, previous cycle's write was discarded
//   fifo_en       : FCR[0], 1 = capacity DEPTH, 0 = capacity 1 (any change flushes)
//   fifo_clr      : FCR[2] pulse, flush the FIFO
//   tx_if         : handshake to uart_tx (master side)
//   thre, temt    : LSR[5], LSR[6]
//   fifo_level    : current occupancy, 0..DEPTH
//   thre_irq_en   : IER[1]
//   thre_irq_ack  : IIR read returned THRE as the source
//   irq_thre      : THR-empty interrupt request (registered)
module uart_tx_ctrl #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     wr_drop,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    uart_tx_ctrl_if.master           tx_if,
    output logic                     thre,
    output logic                     temt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic                     thre_irq_en,
    input  logic                     thre_irq_ack,
    output logic                     irq_thre
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [LvlW-1:0] cap;
    logic            fifo_en_q;
    logic            irq_en_q;
    logic            pend_q, pend_d;
    logic            irq_q;
    logic            drop_q;

    logic            empty;
    logic            pop;
    logic            push;
    logic            flush;
    logic            irq_set;
    logic            irq_clr;

    assign empty = (level_q == '0);

    always_comb begin
        cap   = fifo_en ? LvlW'(DEPTH) : LvlW'(1);
        // A mode change invalidates the buffered layout, so it flushes like FCR[2].
        flush = fifo_clr | (fifo_en ^ fifo_en_q);
        pop   = ~empty & tx_if.tx_ready;
        // A full buffer still accepts a write when the head leaves in the same cycle.
        push  = wr_en & ~flush & ((level_q < cap) | pop);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (flush) begin
            // The popped character (if any) already belongs to uart_tx.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            level_d = level_q + LvlW'(push) - LvlW'(pop);
        end

        irq_set = (~empty & (level_d == '0)) | (thre_irq_en & ~irq_en_q & empty);
        irq_clr = push | thre_irq_ack | ~thre_irq_en;
        // Set has priority over clear.
        pend_d  = irq_set | (pend_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            fifo_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            pend_q    <= 1'b0;
            irq_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            fifo_en_q <= fifo_en;
            irq_en_q  <= thre_irq_en;
            pend_q    <= pend_d;
            irq_q     <= pend_d & thre_irq_en;
            drop_q    <= wr_en & ~push;
        end
    end

    // Character storage carries no reset; contents are only visible while level != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_if.tx_valid = ~empty;
    assign tx_if.tx_data  = mem_q[rd_ptr_q];
    assign thre           = empty;
    assign temt           = empty & tx_if.tx_ready;
    assign fifo_level     = level_q;
    assign wr_drop        = drop_q;
    assign irq_thre       = irq_q;

endmodule
